// File: rtl/core_inst_sequencer.sv
// Purpose: drives core's 64-bit inst word through one 3x3 conv tile (9 kij passes) and a ReLU readout.
// Latency: inst/done are registered, one cycle behind the FSM; start to done pulse is 846 clocks.
// Backpressure: none upstream; each EXEC cycle with ofifo_valid high pops one OFIFO row the next cycle.
//
// Ports: clk, reset (async active-low), start (pulse, honoured only when idle),
//        ofifo_valid (core OFIFO row ready), inst (instruction word), busy, done (pulse),
//        kij_idx (current kernel position).
module core_inst_sequencer #(
    parameter int col      = 8,
    parameter int row      = 8,
    parameter int len_nij  = 36,
    parameter int len_kij  = 9,
    parameter int len_onij = 16,
    parameter int ni_w     = 6,
    parameter int o_w      = 4,
    parameter int k_w      = 3,
    parameter int w_base   = 1024,
    parameter int gap_cyc  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [63:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_WL0, S_WLOAD, S_GAP, S_EXEC, S_FLUSH, S_READ, S_DONE
    } state_t;

    typedef struct packed {
        logic        debug;
        logic [16:0] rsvd_hi;
        logic        relu;
        logic [8:0]  rsvd_mid;
        logic        ren_pmem;
        logic        sfu_pass;
        logic        acc;
        logic        cen_pmem;
        logic        wen_pmem;
        logic [10:0] a_pmem;
        logic        cen_xmem;
        logic        wen_xmem;
        logic [10:0] a_xmem;
        logic        ofifo_rd;
        logic        ififo_wr;
        logic        ififo_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        execute;
        logic        load;
    } inst_t;

    localparam logic [63:0] IDLE_WORD = 64'h0000_0001_000C_0000;

    state_t      state, state_n;
    logic [6:0]  cnt, cnt_n, dur;
    logic [3:0]  kij, kij_n;
    logic [6:0]  nij;
    logic        last;
    inst_t       word, inst_q;
    logic        done_n;

    // Output-pixel mapping for the OFIFO row currently offered (nij) under kernel offset kij.
    logic [6:0]        nij_x, nij_y;
    logic [3:0]        kij_x, kij_y;
    logic signed [8:0] onx, ony;
    logic              in_range;
    logic [10:0]       pmem_addr;

    assign nij_x     = nij % 7'(ni_w);
    assign nij_y     = nij / 7'(ni_w);
    assign kij_x     = kij % 4'(k_w);
    assign kij_y     = kij / 4'(k_w);
    assign onx       = $signed({2'b00, nij_x}) - $signed({5'b00000, kij_x});
    assign ony       = $signed({2'b00, nij_y}) - $signed({5'b00000, kij_y});
    assign in_range  = !onx[8] && !ony[8] && (onx[7:0] < 8'(o_w)) && (ony[7:0] < 8'(o_w));
    assign pmem_addr = 11'(onx[7:0]) + 11'(ony[7:0]) * 11'(o_w);

    always_comb begin
        dur = 7'd1;
        unique case (state)
            S_WL0:   dur = 7'(col + 1);
            S_WLOAD: dur = 7'(1 + col + row);
            S_GAP:   dur = 7'(gap_cyc);
            S_EXEC:  dur = 7'(len_nij + col + row + 1);
            S_FLUSH: dur = 7'd3;
            S_READ:  dur = 7'(len_onij);
            default: dur = 7'd1;
        endcase
    end

    assign last = (cnt == dur - 7'd1);

    always_comb begin
        state_n = state;
        kij_n   = kij;
        unique case (state)
            S_IDLE:  if (start) begin
                         state_n = S_WL0;
                         kij_n   = 4'd0;
                     end
            S_WL0:   if (last) state_n = S_WLOAD;
            S_WLOAD: if (last) state_n = S_GAP;
            S_GAP:   if (last) state_n = S_EXEC;
            S_EXEC:  if (last) state_n = S_FLUSH;
            S_FLUSH: if (last) begin
                         if (kij == 4'(len_kij - 1)) begin
                             state_n = S_READ;
                         end else begin
                             state_n = S_WL0;
                             kij_n   = kij + 4'd1;
                         end
                     end
            S_READ:  if (last) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        // Every state change is a fresh entry, so the per-state counter restarts there.
        cnt_n = (state_n != state || state == S_IDLE) ? 7'd0 : cnt + 7'd1;
    end

    always_comb begin
        word   = inst_t'(IDLE_WORD);
        done_n = 1'b0;
        unique case (state)
            S_WL0: begin
                word.cen_xmem = 1'b0;
                word.a_xmem   = 11'(w_base) + 11'(col) * 11'(kij) + 11'(cnt);
                // Row read on cnt lands in L0 one cycle later (SRAM read latency).
                word.l0_wr    = (cnt != 7'd0);
            end
            S_WLOAD: begin
                word.l0_rd = 1'b1;
                word.load  = (cnt != 7'd0);
            end
            S_EXEC: begin
                if (cnt < 7'(len_nij)) begin
                    word.cen_xmem = 1'b0;
                    word.a_xmem   = 11'(cnt);
                    word.l0_wr    = 1'b1;
                    word.l0_rd    = 1'b1;
                    word.execute  = 1'b1;
                end
                // Rows outside the valid output window are popped and dropped.
                if (ofifo_valid) begin
                    word.ofifo_rd = 1'b1;
                    word.acc      = (kij != 4'd0);
                    word.sfu_pass = (kij == 4'd0);
                    word.relu     = (kij == 4'(len_kij - 1));
                    if (in_range) begin
                        word.cen_pmem = 1'b0;
                        word.wen_pmem = 1'b1;
                        word.a_pmem   = pmem_addr;
                    end
                end
            end
            S_READ: begin
                word.cen_pmem = 1'b0;
                word.wen_pmem = 1'b0;
                word.a_pmem   = 11'(cnt);
                word.relu     = 1'b1;
            end
            S_DONE:  done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= 7'd0;
            kij    <= 4'd0;
            nij    <= 7'd0;
            inst_q <= inst_t'(IDLE_WORD);
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            kij    <= kij_n;
            inst_q <= word;
            done   <= done_n;
            if (state != S_EXEC) begin
                nij <= 7'd0;
            end else if (ofifo_valid && nij != 7'h7f) begin
                nij <= nij + 7'd1;
            end
        end
    end

    assign inst    = inst_q;
    assign busy    = (state != S_IDLE);
    assign kij_idx = kij;

endmodule
